// File: rtl/bfp_block_align_ctrl.sv
// Block-floating-point alignment controller: buffers one block of single-precision
// words, emits a shared-exponent header, then each word aligned to that exponent.
module bfp_block_align_ctrl #(
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_hdr,
  output logic        out_last,
  output logic        busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {FILL, HDR, DRAIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, idx, idx_n, idx_inc;
  logic [7:0]        emax, emax_n, emax_upd;
  logic [CNT_W-1:0]  blk_n, blk_n_n;
  logic [31:0]       out_data_n;
  logic              out_valid_n, out_hdr_n, out_last_n;
  logic              in_fire, out_fire, close;
  logic [31:0]       mem [BLOCK_LEN];

  // Shift a word's mantissa down to the shared exponent; the sign survives a zero result.
  function automatic logic [31:0] align(input logic [31:0] w, input logic [7:0] em);
    logic [7:0]  sh;
    logic [23:0] mag;
    sh = em - w[30:23];
    if (w[30:23] == 8'd0 || sh >= 8'd24) mag = 24'd0;
    else                                 mag = {1'b1, w[22:0]} >> sh;
    return {w[31], 7'b0, mag};
  endfunction

  assign in_ready = (state == FILL);
  assign busy     = (state != FILL);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign idx_inc  = idx + ADDR_W'(1);
  assign emax_upd = (in_data[30:23] > emax) ? in_data[30:23] : emax;
  assign close    = in_fire & (in_last | (cnt == ADDR_W'(BLOCK_LEN - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FILL:    if (close)               state_n = HDR;
      HDR:     if (out_fire)            state_n = DRAIN;
      DRAIN:   if (out_fire && out_last) state_n = FILL;
      default:                          state_n = FILL;
    endcase
  end

  // Next values for the registered outputs and block bookkeeping; hold by default.
  always_comb begin
    cnt_n       = cnt;
    idx_n       = idx;
    emax_n      = emax;
    blk_n_n     = blk_n;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    out_hdr_n   = out_hdr;
    out_last_n  = out_last;
    case (state)
      FILL: begin
        if (in_fire) begin
          cnt_n  = cnt + ADDR_W'(1);
          emax_n = emax_upd;
        end
        if (close) begin
          blk_n_n     = CNT_W'(cnt) + CNT_W'(1);
          out_valid_n = 1'b1;
          out_hdr_n   = 1'b1;
          out_last_n  = 1'b0;
          out_data_n  = {16'h0, 8'(cnt), emax_upd};
        end
      end
      HDR: begin
        if (out_fire) begin
          idx_n      = '0;
          out_hdr_n  = 1'b0;
          out_data_n = align(mem[0], emax);
          out_last_n = (blk_n == CNT_W'(1));
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (out_last) begin
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            out_data_n  = 32'd0;
            cnt_n       = '0;
            emax_n      = 8'd0;
          end else begin
            idx_n      = idx_inc;
            out_data_n = align(mem[idx_inc], emax);
            out_last_n = ((CNT_W'(idx) + CNT_W'(2)) == blk_n);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      emax      <= 8'd0;
      blk_n     <= '0;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
      out_hdr   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      idx       <= idx_n;
      emax      <= emax_n;
      blk_n     <= blk_n_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      out_hdr   <= out_hdr_n;
      out_last  <= out_last_n;
    end
  end

  // Block buffer needs no reset: stale entries are never read once cnt restarts.
  always_ff @(posedge clk) begin
    if (in_fire) mem[cnt] <= in_data;
  end

endmodule

// File: tb/tb_bfp_block_align_ctrl.sv
// Directed bench for bfp_block_align_ctrl: hand-computed headers and aligned words.
module tb_bfp_block_align_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid, in_ready, in_last;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_hdr, out_last, busy;

  int checks   = 0;
  int failures = 0;
  int span;

  logic [31:0] vin   [16];
  logic [31:0] exp_d [17];
  logic [31:0] got_d [$];
  logic        got_h [$];
  logic        got_l [$];

  bfp_block_align_ctrl #(.BLOCK_LEN(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_hdr(out_hdr), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Feed vin[0..n-1]; the header must be on the output the cycle after the closing word.
  task automatic send(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("send_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = vin[i];
      in_last  = use_last && (i == n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("hdr_valid", 32'(out_valid), 32'd1);
    check("hdr_flag", 32'(out_hdr), 32'd1);
    check("hdr_in_ready", 32'(in_ready), 32'd0);
    check("hdr_busy", 32'(busy), 32'd1);
  endtask

  // Record every output transfer until out_last; optional stall or reset at a data index.
  task automatic collect(input int bp_at, input int rst_at, input bit chk_rdy);
    int cyc, ndat;
    bit done;
    logic [31:0] snap_d;
    logic snap_l;
    got_d.delete(); got_h.delete(); got_l.delete();
    cyc = 0; ndat = 0; done = 1'b0; span = 0;
    while (!done && cyc < 200) begin
      if (chk_rdy) check("drain_in_ready", 32'(in_ready), 32'd0);
      if (bp_at >= 0 && ndat == bp_at && out_valid) begin
        snap_d = out_data;
        snap_l = out_last;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          cyc++;
          check("bp_data", out_data, snap_d);
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_last", 32'(out_last), 32'(snap_l));
        end
        out_ready = 1'b1;
        bp_at = -1;
      end
      if (rst_at >= 0 && ndat == rst_at && out_valid) begin
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done = 1'b1;
      end else begin
        if (out_valid && out_ready) begin
          got_d.push_back(out_data);
          got_h.push_back(out_hdr);
          got_l.push_back(out_last);
          if (!out_hdr) ndat++;
          if (out_last) begin
            done = 1'b1;
            span = cyc + 1;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL collect_timeout observed=%0d cycles expected=out_last", cyc);
    end
  endtask

  // Compare the recorded transfers against exp_d[0..n-1] (entry 0 is the header).
  task automatic verify(input string tag, input int n);
    check({tag, "_count"}, 32'(got_d.size()), 32'(n));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_hdr%0d", tag, i), 32'(got_h[i]), 32'(i == 0));
      check($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == n - 1));
    end
    check({tag, "_after_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_after_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic load16();
    for (int i = 0; i < 16; i++) vin[i] = 32'h3F800000;
    vin[1] = 32'h40000000;
    exp_d[0] = 32'h00000F80;
    for (int i = 1; i < 17; i++) exp_d[i] = 32'h00400000;
    exp_d[2] = 32'h00800000;
  endtask

  initial begin
    rst = 1'b0; in_data = 32'd0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #3 rst = 1'b1;
    #4;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_hdr", 32'(out_hdr), 32'd0);
    check("reset_out_last", 32'(out_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Full 16-word block closed by count, streamed back-to-back.
    load16();
    send(16, 1'b0);
    collect(-1, -1, 1'b0);
    verify("t1", 17);
    check("t1_span", 32'(span), 32'd17);

    // Partial block closed by in_last on the third word.
    vin[0] = 32'h40400000; vin[1] = 32'hC0000000; vin[2] = 32'h3F000000;
    exp_d[0] = 32'h00000280; exp_d[1] = 32'h00C00000;
    exp_d[2] = 32'h80800000; exp_d[3] = 32'h00200000;
    send(3, 1'b1);
    collect(-1, -1, 1'b0);
    verify("t2", 4);

    // Signed zero, underflow past 24 bits, and the max-exponent word.
    vin[0] = 32'h80000000; vin[1] = 32'h32000000; vin[2] = 32'h41000000;
    exp_d[0] = 32'h00000282; exp_d[1] = 32'h80000000;
    exp_d[2] = 32'h00000000; exp_d[3] = 32'h00800000;
    send(3, 1'b1);
    collect(-1, -1, 1'b0);
    verify("t3", 4);

    // Infinity sets emax=255; the other word shifts out entirely.
    vin[0] = 32'h7F800000; vin[1] = 32'h3F800000;
    exp_d[0] = 32'h000001FF; exp_d[1] = 32'h00800000; exp_d[2] = 32'h00000000;
    send(2, 1'b1);
    collect(-1, -1, 1'b0);
    verify("t_inf", 3);

    // Full block with in_last on the 16th word, stalled for 5 cycles at idx 4.
    load16();
    send(16, 1'b1);
    collect(4, -1, 1'b0);
    verify("t4", 17);
    repeat (3) begin
      @(negedge clk);
      check("t4_no_empty_block", 32'(out_valid), 32'd0);
    end

    // in_valid held through the drain: the pending word lands only after out_last.
    vin[0] = 32'h40000000; vin[1] = 32'hBF800000;
    exp_d[0] = 32'h00000180; exp_d[1] = 32'h00800000; exp_d[2] = 32'h80400000;
    send(2, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h40800000;
    collect(-1, -1, 1'b1);
    verify("t5", 3);
    vin[0] = 32'h3F800000;
    exp_d[0] = 32'h00000181; exp_d[1] = 32'h00800000; exp_d[2] = 32'h00200000;
    send(1, 1'b1);
    collect(-1, -1, 1'b0);
    verify("t5b", 3);

    // Reset mid-drain at idx 7, then a clean 2-word block.
    load16();
    send(16, 1'b0);
    collect(-1, 7, 1'b0);
    vin[0] = 32'h3F800000; vin[1] = 32'h40000000;
    exp_d[0] = 32'h00000180; exp_d[1] = 32'h00400000; exp_d[2] = 32'h00800000;
    send(2, 1'b1);
    collect(-1, -1, 1'b0);
    verify("t6", 3);
    repeat (3) begin
      @(negedge clk);
      check("t6_no_stale", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
